pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  Consumer of the branch comparator's taken flag (branch_e): owns the PC, issues
//  instruction-fetch requests over a valid/ready handshake, and redirects fetch on
//  taken branches/jumps. Emits a one-cycle flush and toggles a fetch epoch so
//  IF/ID drop wrong-path instructions. Sits between execute stage and instruction memory.
// PARAMETERS
//  XLEN          32            address width
//  RESET_VECTOR  32'h0000_0000 PC value loaded at reset
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst_n          in   1     asynchronous active-low reset
//  ex_valid       in   1     execute-stage instruction valid
//  branch_e       in   1     conditional branch taken (from branch comparator)
//  jump_e         in   1     unconditional jump (JAL/JALR)
//  target_addr    in   XLEN  redirect target, valid when ex_valid
//  stall          in   1     hazard stall: no new fetch request
//  fetch_req      out  1     fetch request valid
//  fetch_addr     out  XLEN  fetch address (= pc)
//  fetch_ready    in   1     memory accepts request this cycle
//  fetch_epoch    out  1     epoch tag; toggles on every accepted redirect
//  flush          out  1     one-cycle pulse: kill IF/ID
//  misalign_exc   out  1     one-cycle pulse: misaligned redirect target
//  misalign_addr  out  XLEN  offending target, held until next exception
//  trap_ack       in   1     trap handler vector valid
//  trap_vector    in   XLEN  new PC after trap
// BEHAVIOUR
//  Reset: pc=RESET_VECTOR, state=BOOT, fetch_req=0, flush=0, misalign_exc=0,
//   misalign_addr=0, fetch_epoch=0, req_hold=0, pending=0.
//  States: BOOT -> RUN unconditionally on first clock after reset release.
//   RUN: fetch_req = req_hold | ~stall. req_hold set when fetch_req & ~fetch_ready,
//    cleared on acceptance; a presented request never drops or changes address
//    until accepted (stall cannot withdraw it).
//   Accept (fetch_req & fetch_ready), no redirect: pc <= pc+4 (mod 2^XLEN).
//   take = ex_valid & (branch_e | jump_e) (both high = one take).
//   take, target aligned: flush=1 and epoch toggles next cycle (registered, 1-cycle
//    latency). If no held request or request accepted this cycle: pc <= target_addr,
//    stay RUN. If request held unaccepted: pending <= target_addr, -> PENDING.
//   PENDING: fetch_req=1 at old pc; on accept pc <= pending, -> RUN. A new take here
//    overwrites pending, pulses flush, toggles epoch again.
//   take, target misaligned: misalign_exc pulse, misalign_addr <= target_addr,
//    flush pulse, epoch toggle; -> TRAP (-> TRAP_HOLD if request held; TRAP entered
//    on its acceptance). TRAP: fetch_req=0, pc held, take ignored.
//   trap_ack (any state, highest priority over take): pc <= trap_vector, flush pulse,
//    epoch toggle; -> RUN, or PENDING with pending=trap_vector if request held.
//  Priority: trap_ack > take > stall. Stall never blocks redirect state update.
//  Alignment: target_addr[1:0]!=0 is misaligned. trap_vector assumed aligned by CSR unit.
//  Reset mid-handshake: all state cleared immediately; held request abandoned.
// CONFIGURATION
//  PC_RVC_EN defined: compressed support; misaligned only if target_addr[0]!=0;
//   increment still +4 (fetch unit re-aligns halfwords).
//  PC_RVC_EN undefined: misaligned if target_addr[1:0]!=0.
// TESTING
//  1 reset release, fetch_ready=1 -> fetch_addr 0,4,8,C on consecutive cycles, epoch=0.
//  2 fetch_ready=0 3 cycles with stall=1 at 0x8 -> fetch_req stays 1, addr stays 0x8.
//  3 ex_valid&branch_e, target 0x100, ready=1 -> next cycle flush=1, epoch=1,
//    fetch_addr=0x100, then 0x104.
//  4 jump_e target 0x200 while 0x10 held unaccepted -> addr stays 0x10 until ready,
//    then 0x200; flush one pulse; second take to 0x300 in PENDING -> 0x300 fetched.
//  5 take target 0x102 -> misalign_exc=1, misalign_addr=0x102, fetch_req=0;
//    trap_ack vector 0x80 -> fetch 0x80. With PC_RVC_EN: 0x102 fetched, 0x103 traps.
//  6 pc=0xFFFF_FFFC accepted -> next fetch_addr 0x0; take+trap_ack same cycle -> trap_vector.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
//
// Owns the program counter and drives instruction-fetch requests over a
// valid/ready handshake. Taken branches/jumps from execute redirect fetch,
// raise a one-cycle flush and toggle the fetch epoch so IF/ID can drop
// wrong-path instructions. A misaligned redirect target raises a one-cycle
// misalign exception and parks fetch until the trap handler vector arrives.
//
// Configuration macro:
//   PC_RVC_EN  defined   -> compressed support, only target_addr[0] must be 0
//              undefined -> target_addr[1:0] must be 0
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   ex_valid       execute-stage instruction valid
//   branch_e       conditional branch taken
//   jump_e         unconditional jump
//   target_addr    redirect target
//   stall          hazard stall, suppresses new fetch requests
//   fetch_req      fetch request valid
//   fetch_addr     fetch address (the PC)
//   fetch_ready    memory accepts the request this cycle
//   fetch_epoch    epoch tag, toggles on every redirect
//   flush          one-cycle pulse killing IF/ID
//   misalign_exc   one-cycle pulse on a misaligned redirect target
//   misalign_addr  offending target, held until the next exception
//   trap_ack       trap handler vector valid
//   trap_vector    new PC after a trap
// -----------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic [XLEN-1:0] target_addr,
  input  logic            stall,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_ready,
  output logic            fetch_epoch,
  output logic            flush,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr,
  input  logic            trap_ack,
  input  logic [XLEN-1:0] trap_vector
);

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_RUN       = 3'd1,
    ST_PENDING   = 3'd2,  // redirect waiting for the held request to be accepted
    ST_TRAP      = 3'd3,  // fetch parked until trap_ack
    ST_TRAP_HOLD = 3'd4   // trap decided, held request still outstanding
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pending_r;
  logic            req_hold_r;
  logic            flush_r;
  logic            epoch_r;
  logic            misalign_exc_r;
  logic [XLEN-1:0] misalign_addr_r;

  logic fetch_req_s;
  logic accept_s;
  logic held_s;
  logic take_s;
  logic misalign_s;
  logic redirect_s;

  // Redirect target alignment check; compressed builds only need halfword alignment.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
`ifdef PC_RVC_EN
    return addr[0];
`else
    return |addr[1:0];
`endif
  endfunction

  // Request valid and handshake qualifiers derived from the current state.
  always_comb begin
    fetch_req_s = 1'b0;
    case (state_r)
      // Once presented, a request is held regardless of stall.
      ST_RUN:                   fetch_req_s = req_hold_r | ~stall;
      ST_PENDING, ST_TRAP_HOLD: fetch_req_s = 1'b1;
      default:                  fetch_req_s = 1'b0;
    endcase
    accept_s   = fetch_req_s & fetch_ready;
    held_s     = fetch_req_s & ~fetch_ready;
    // Takes are only honoured while fetch is live; a trap in flight ignores them.
    take_s     = ((state_r == ST_RUN) | (state_r == ST_PENDING)) & ex_valid & (branch_e | jump_e);
    misalign_s = is_misaligned(target_addr);
    redirect_s = trap_ack | take_s;
  end

  // PC, redirect state machine and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_BOOT;
      pc_r            <= RESET_VECTOR;
      pending_r       <= {XLEN{1'b0}};
      req_hold_r      <= 1'b0;
      flush_r         <= 1'b0;
      epoch_r         <= 1'b0;
      misalign_exc_r  <= 1'b0;
      misalign_addr_r <= {XLEN{1'b0}};
    end else begin
      flush_r        <= redirect_s;
      epoch_r        <= epoch_r ^ redirect_s;
      misalign_exc_r <= 1'b0;
      req_hold_r     <= held_s;
      if (trap_ack) begin
        // An outstanding request must complete at its old address first.
        if (held_s) begin
          pending_r <= trap_vector;
          state_r   <= ST_PENDING;
        end else begin
          pc_r    <= trap_vector;
          state_r <= ST_RUN;
        end
      end else if (take_s && misalign_s) begin
        // PC is left alone; the trap handler supplies the next fetch address.
        misalign_exc_r  <= 1'b1;
        misalign_addr_r <= target_addr;
        state_r         <= held_s ? ST_TRAP_HOLD : ST_TRAP;
      end else if (take_s) begin
        if (held_s) begin
          pending_r <= target_addr;
          state_r   <= ST_PENDING;
        end else begin
          pc_r    <= target_addr;
          state_r <= ST_RUN;
        end
      end else begin
        case (state_r)
          ST_BOOT: state_r <= ST_RUN;
          ST_RUN: begin
            if (accept_s) begin
              pc_r <= pc_r + PC_STEP;
            end else begin
              pc_r <= pc_r;
            end
          end
          ST_PENDING: begin
            if (accept_s) begin
              pc_r    <= pending_r;
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_PENDING;
            end
          end
          ST_TRAP_HOLD: begin
            if (accept_s) begin
              state_r <= ST_TRAP;
            end else begin
              state_r <= ST_TRAP_HOLD;
            end
          end
          ST_TRAP: state_r <= ST_TRAP;
          default: state_r <= ST_BOOT;
        endcase
      end
    end
  end

  assign fetch_req     = fetch_req_s;
  assign fetch_addr    = pc_r;
  assign fetch_epoch   = epoch_r;
  assign flush         = flush_r;
  assign misalign_exc  = misalign_exc_r;
  assign misalign_addr = misalign_addr_r;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_unit
//
// Directed vector table and hand-written redirect/trap sequences, followed by
// randomized traffic checked against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, branch_e, jump_e, stall, fetch_ready, trap_ack;
  logic [31:0] target_addr, trap_vector;
  logic        fetch_req, fetch_epoch, flush, misalign_exc;
  logic [31:0] fetch_addr, misalign_addr;

  int n_total = 0;
  int n_pass  = 0;

`ifdef PC_RVC_EN
  localparam logic [31:0] BAD = 32'h0000_0103;
`else
  localparam logic [31:0] BAD = 32'h0000_0102;
`endif

  pc_redirect_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .branch_e(branch_e),
    .jump_e(jump_e), .target_addr(target_addr), .stall(stall),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_epoch(fetch_epoch), .flush(flush), .misalign_exc(misalign_exc),
    .misalign_addr(misalign_addr), .trap_ack(trap_ack), .trap_vector(trap_vector)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s, r, ev, br, jp;
    logic [31:0] tgt;
    logic        ta;
    logic [31:0] tv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fl, e_ep, e_exc;
    logic [31:0] e_ma;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic ev, input logic br,
                              input logic jp, input logic [31:0] tgt, input logic ta,
                              input logic [31:0] tv, input logic e_req, input logic [31:0] e_addr,
                              input logic e_fl, input logic e_ep, input logic e_exc,
                              input logic [31:0] e_ma);
    vec_t v;
    v.s = s; v.r = r; v.ev = ev; v.br = br; v.jp = jp; v.tgt = tgt; v.ta = ta; v.tv = tv;
    v.e_req = e_req; v.e_addr = e_addr; v.e_fl = e_fl; v.e_ep = e_ep; v.e_exc = e_exc; v.e_ma = e_ma;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic drive(input logic s, input logic r, input logic ev, input logic br,
                       input logic jp, input logic [31:0] tgt, input logic ta, input logic [31:0] tv);
    stall = s; fetch_ready = r; ex_valid = ev; branch_e = br; jump_e = jp;
    target_addr = tgt; trap_ack = ta; trap_vector = tv;
  endtask

  // Drive at the negedge, check 1ns later, then advance one full cycle.
  task automatic apply(input vec_t v, input string tag);
    drive(v.s, v.r, v.ev, v.br, v.jp, v.tgt, v.ta, v.tv);
    #1;
    chk({tag, ".req"},   {31'd0, fetch_req},    {31'd0, v.e_req});
    chk({tag, ".addr"},  fetch_addr,            v.e_addr);
    chk({tag, ".flush"}, {31'd0, flush},        {31'd0, v.e_fl});
    chk({tag, ".epoch"}, {31'd0, fetch_epoch},  {31'd0, v.e_ep});
    chk({tag, ".exc"},   {31'd0, misalign_exc}, {31'd0, v.e_exc});
    chk({tag, ".maddr"}, misalign_addr,         v.e_ma);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Behavioural model state.
  logic        m_booted, m_hold, m_redir, m_trapped, m_trap_after;
  logic        m_epoch, m_flush, m_exc;
  logic [31:0] m_pc, m_redir_addr, m_ma;

  task automatic model_reset();
    m_booted = 1'b0; m_hold = 1'b0; m_redir = 1'b0; m_trapped = 1'b0; m_trap_after = 1'b0;
    m_epoch = 1'b0; m_flush = 1'b0; m_exc = 1'b0;
    m_pc = 32'd0; m_redir_addr = 32'd0; m_ma = 32'd0;
  endtask

  function automatic logic model_req(input logic s);
    return m_booted && !m_trapped && (m_trap_after || m_redir || m_hold || !s);
  endfunction

  function automatic logic bad_align(input logic [31:0] a);
`ifdef PC_RVC_EN
    return a[0];
`else
    return a[1:0] != 2'b00;
`endif
  endfunction

  task automatic model_step();
    logic req, acc, held, take, mis;
    req  = model_req(stall);
    acc  = req && fetch_ready;
    held = req && !fetch_ready;
    take = ex_valid && (branch_e || jump_e) && m_booted && !m_trapped && !m_trap_after;
    mis  = take && bad_align(target_addr);
    m_flush = trap_ack || take;
    m_epoch = m_epoch ^ (trap_ack || take);
    m_exc   = !trap_ack && mis;
    if (m_exc) m_ma = target_addr;
    if (trap_ack) begin
      m_booted = 1'b1; m_trapped = 1'b0; m_trap_after = 1'b0;
      if (held) begin m_redir = 1'b1; m_redir_addr = trap_vector; end
      else begin m_redir = 1'b0; m_pc = trap_vector; end
    end else if (!m_booted) begin
      m_booted = 1'b1;
    end else if (m_trapped) begin
      // parked until trap_ack
    end else if (mis) begin
      m_redir = 1'b0;
      if (held) m_trap_after = 1'b1; else m_trapped = 1'b1;
    end else if (take) begin
      if (held) begin m_redir = 1'b1; m_redir_addr = target_addr; end
      else begin m_redir = 1'b0; m_pc = target_addr; end
    end else if (acc) begin
      if (m_trap_after) begin m_trapped = 1'b1; m_trap_after = 1'b0; end
      else if (m_redir) begin m_pc = m_redir_addr; m_redir = 1'b0; end
      else m_pc = m_pc + 32'd4;
    end
    m_hold = held;
  endtask

  vec_t tbl[14];

  initial begin
    // Boot, sequential fetch, held request under stall, aligned branch.
    tbl[0]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b0,32'h00, 1'b0,1'b0,1'b0,32'h0);
    tbl[1]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h00, 1'b0,1'b0,1'b0,32'h0);
    tbl[2]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h04, 1'b0,1'b0,1'b0,32'h0);
    tbl[3]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h08, 1'b0,1'b0,1'b0,32'h0);
    tbl[4]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h0C, 1'b0,1'b0,1'b0,32'h0);
    tbl[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h10, 1'b0,1'b0,1'b0,32'h0);
    tbl[6]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h10, 1'b0,1'b0,1'b0,32'h0);
    tbl[7]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h10, 1'b0,1'b0,1'b0,32'h0);
    tbl[8]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h10, 1'b0,1'b0,1'b0,32'h0);
    tbl[9]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h10, 1'b0,1'b0,1'b0,32'h0);
    tbl[10] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b0,32'h14, 1'b0,1'b0,1'b0,32'h0);
    tbl[11] = mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h100,1'b0,32'h0, 1'b1,32'h14, 1'b0,1'b0,1'b0,32'h0);
    tbl[12] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h100,1'b1,1'b1,1'b0,32'h0);
    tbl[13] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h104,1'b0,1'b1,1'b0,32'h0);

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Jump while a request is held, then a second take in PENDING.
    apply(mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h108,1'b0,1'b1,1'b0,32'h0), "pend0");
    apply(mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h200,1'b0,32'h0, 1'b1,32'h108,1'b0,1'b1,1'b0,32'h0), "pend1");
    apply(mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h108,1'b1,1'b0,1'b0,32'h0), "pend2");
    apply(mk(1'b1,1'b0,1'b1,1'b1,1'b0,32'h300,1'b0,32'h0, 1'b1,32'h108,1'b0,1'b0,1'b0,32'h0), "pend3");
    apply(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h108,1'b1,1'b1,1'b0,32'h0), "pend4");
    apply(mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h300,1'b0,1'b1,1'b0,32'h0), "pend5");

    // Misaligned target, ignored take while trapped, trap handler vector.
    apply(mk(1'b0,1'b1,1'b1,1'b1,1'b0,BAD,    1'b0,32'h0, 1'b1,32'h304,1'b0,1'b1,1'b0,32'h0), "mis0");
    apply(mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b0,32'h304,1'b1,1'b0,1'b1,BAD),   "mis1");
    apply(mk(1'b0,1'b1,1'b1,1'b0,1'b1,32'h400,1'b0,32'h0, 1'b0,32'h304,1'b0,1'b0,1'b0,BAD),   "mis2");
    apply(mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h80,1'b0,32'h304,1'b0,1'b0,1'b0,BAD),   "mis3");
    apply(mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h80, 1'b1,1'b1,1'b0,BAD),   "mis4");

    // PC wrap, then take and trap_ack together (trap wins, one toggle).
    apply(mk(1'b0,1'b1,1'b1,1'b0,1'b1,32'hFFFF_FFFC,1'b0,32'h0,1'b1,32'h84,1'b0,1'b1,1'b0,BAD), "wrap0");
    apply(mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hFFFF_FFFC,1'b1,1'b0,1'b0,BAD),  "wrap1");
    apply(mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h500,1'b1,32'h40,1'b1,32'h0,1'b0,1'b0,1'b0,BAD),       "prio0");
    apply(mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0, 1'b1,32'h40, 1'b1,1'b1,1'b0,BAD),     "prio1");

    // trap_ack while a request is held: old address completes first.
    apply(mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,  1'b1,32'h44, 1'b0,1'b1,1'b0,BAD), "tah0");
    apply(mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h800,1'b1,32'h44, 1'b0,1'b1,1'b0,BAD), "tah1");
    apply(mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,  1'b1,32'h44, 1'b1,1'b0,1'b0,BAD), "tah2");
    apply(mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,  1'b1,32'h800,1'b0,1'b0,1'b0,BAD), "tah3");
    apply(mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,  1'b1,32'h804,1'b0,1'b0,1'b0,BAD), "tah4");

    // Reset while the request at 0x804 is held: cleared immediately.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.req",   {31'd0, fetch_req},    32'd0);
    chk("rst.addr",  fetch_addr,            32'd0);
    chk("rst.epoch", {31'd0, fetch_epoch},  32'd0);
    chk("rst.flush", {31'd0, flush},        32'd0);
    chk("rst.exc",   {31'd0, misalign_exc}, 32'd0);
    chk("rst.maddr", misalign_addr,         32'd0);
    @(negedge clk);
    do_reset();
    model_reset();

    // Randomized traffic against the behavioural model.
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(7) != 0) t[1:0] = 2'b00;
      drive($urandom_range(3) == 0, $urandom_range(2) != 0, $urandom_range(2) == 0,
            1'($urandom), 1'($urandom), t, $urandom_range(39) == 0, {$urandom, 2'b00} & 32'hFFFF_FFFC);
      #1;
      chk("rnd.req",   {31'd0, fetch_req},    {31'd0, model_req(stall)});
      chk("rnd.addr",  fetch_addr,            m_pc);
      chk("rnd.flush", {31'd0, flush},        {31'd0, m_flush});
      chk("rnd.epoch", {31'd0, fetch_epoch},  {31'd0, m_epoch});
      chk("rnd.exc",   {31'd0, misalign_exc}, {31'd0, m_exc});
      chk("rnd.maddr", misalign_addr,         m_ma);
      model_step();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
